// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches over req/ack, presents {pc,instr} to IF_ID.
// Ports: clk_i/rst_i (async low), start_i, stall_i, branch_i/branch_target_i,
//  imem_req_o/imem_addr_o/imem_ack_i/imem_data_i, pc_o/instr_o/instr_valid_o,
//  mem_stall_o (no live instr while fetching).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        mem_stall_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_ins;
  logic        r_out_vld;
  logic [31:0] r_sk_pc;
  logic [31:0] r_sk_ins;
  logic        r_sk_vld;

  logic [1:0]  w_state_n;
  logic [31:0] w_pc_n;
  logic [31:0] w_addr_n;
  logic [31:0] w_out_pc_n;
  logic [31:0] w_out_ins_n;
  logic        w_out_vld_n;
  logic [31:0] w_sk_pc_n;
  logic [31:0] w_sk_ins_n;
  logic        w_sk_vld_n;

  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;
  logic        w_consume;
  logic        w_ack;
  logic        w_req;

  assign w_req     = (r_state == S_FETCH) ||
                     (r_state == S_DROP);
  assign w_tgt     = {branch_target_i[31:2], 2'b00};
  assign w_pc_inc  = r_pc + PC_INC;
  assign w_consume = r_out_vld & ~stall_i;
  assign w_ack     = imem_ack_i & w_req;

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_addr_n    = r_addr;
    w_out_pc_n  = r_out_pc;
    w_out_ins_n = r_out_ins;
    w_out_vld_n = r_out_vld & ~w_consume;
    w_sk_pc_n   = r_sk_pc;
    w_sk_ins_n  = r_sk_ins;
    w_sk_vld_n  = r_sk_vld;
    unique case (r_state)
      S_IDLE: begin
        if (branch_i) begin
          w_pc_n = w_tgt;
        end else if (start_i) begin
          w_state_n = S_FETCH;
          w_addr_n  = r_pc;
        end
      end
      S_FETCH: begin
        if (branch_i) begin
          w_pc_n = w_tgt;
          // ack on the redirect edge closes the old
          // transaction, so the target can go out now
          if (w_ack) w_addr_n  = w_tgt;
          else       w_state_n = S_DROP;
        end else if (w_ack) begin
          if (!r_out_vld || w_consume) begin
            w_out_pc_n  = r_pc;
            w_out_ins_n = imem_data_i;
            w_out_vld_n = 1'b1;
          end else begin
            w_sk_pc_n  = r_pc;
            w_sk_ins_n = imem_data_i;
            w_sk_vld_n = 1'b1;
          end
          w_pc_n   = w_pc_inc;
          w_addr_n = w_pc_inc;
          if (r_out_vld && !w_consume)
            w_state_n = S_HOLD;
          else if (!start_i)
            w_state_n = S_IDLE;
        end
      end
      S_HOLD: begin
        if (branch_i) begin
          w_pc_n    = w_tgt;
          w_addr_n  = w_tgt;
          w_state_n = S_FETCH;
        end else if (w_consume) begin
          w_out_pc_n  = r_sk_pc;
          w_out_ins_n = r_sk_ins;
          w_out_vld_n = 1'b1;
          w_sk_vld_n  = 1'b0;
          w_addr_n    = r_pc;
          w_state_n   = start_i ? S_FETCH : S_IDLE;
        end
      end
      S_DROP: begin
        if (branch_i) w_pc_n = w_tgt;
        // stale data is discarded; the newest
        // target (if any) is fetched next
        if (w_ack) begin
          w_addr_n  = branch_i ? w_tgt : r_pc;
          w_state_n = start_i ? S_FETCH : S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (branch_i) begin
      w_out_vld_n = 1'b0;
      w_sk_vld_n  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_out_pc  <= 32'h0;
      r_out_ins <= 32'h0;
      r_out_vld <= 1'b0;
      r_sk_pc   <= 32'h0;
      r_sk_ins  <= 32'h0;
      r_sk_vld  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_addr    <= w_addr_n;
      r_out_pc  <= w_out_pc_n;
      r_out_ins <= w_out_ins_n;
      r_out_vld <= w_out_vld_n;
      r_sk_pc   <= w_sk_pc_n;
      r_sk_ins  <= w_sk_ins_n;
      r_sk_vld  <= w_sk_vld_n;
    end
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_addr;
  assign pc_o          = r_out_pc;
  assign instr_o       = r_out_ins;
  assign instr_valid_o = r_out_vld;
  assign mem_stall_o   = ~r_out_vld &
                         (r_state != S_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus
// random traffic against a program-order scoreboard.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        mem_stall_o;

  instr_fetch_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o),
    .mem_stall_o     (mem_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  int          checks = 0;
  int          errors = 0;
  item_t       q[$];
  item_t       m_e;
  logic [31:0] mpc = 32'h0;
  bit          stale = 1'b0;
  bit          p_req, p_ack, p_br;
  logic [31:0] p_tgt, p_addr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // monitor: every consumed slot must be the next
  // instruction in program order
  always @(negedge clk_i) begin
    if (rst_i && instr_valid_o && !stall_i) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual pc=%h required=none",
                 pc_o);
      end else begin
        m_e = q.pop_front();
        chk("sb_pc", pc_o, m_e.pc);
        chk("sb_instr", instr_o, m_e.ins);
      end
    end
  end

  // drive one cycle, then apply the reference model
  // for the edge just taken
  task automatic step(input bit s, input bit st,
                      input bit br,
                      input logic [31:0] tg,
                      input bit a);
    start_i         = s;
    stall_i         = st;
    branch_i        = br;
    branch_target_i = tg;
    imem_ack_i      = a && imem_req_o;
    imem_data_i     = imem_addr_o ^ 32'hA5A5_0000;
    p_req  = imem_req_o;
    p_ack  = imem_ack_i;
    p_br   = br;
    p_tgt  = tg;
    p_addr = imem_addr_o;
    @(posedge clk_i);
    #1;
    if (p_req && p_ack) begin
      if (!stale) begin
        chk("fetch_addr", p_addr, mpc);
        if (!p_br) begin
          q.push_back({mpc, mpc ^ 32'hA5A5_0000});
          mpc = mpc + 32'd4;
        end
      end
      stale = 1'b0;
    end else if (p_req && p_br) begin
      stale = 1'b1;
    end
    if (p_br) begin
      q.delete();
      mpc = {p_tgt[31:2], 2'b00};
    end
  endtask

  task automatic do_reset();
    rst_i      = 1'b0;
    imem_ack_i = 1'b0;
    branch_i   = 1'b0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_mstall", mem_stall_o, 0);
    q.delete();
    stale = 1'b0;
    mpc   = 32'h0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    int n;
    #2;
    do_reset();

    // streaming, one instruction per cycle
    step(1, 0, 0, 0, 1);
    chk("t1_req", imem_req_o, 1);
    chk("t1_addr0", imem_addr_o, 0);
    chk("t1_valid0", instr_valid_o, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 1);
      chk("t1_valid", instr_valid_o, 1);
      chk("t1_pc", pc_o, 32'(i * 4));
      chk("t1_addr", imem_addr_o, 32'(i * 4 + 4));
      chk("t1_mstall", mem_stall_o, 0);
    end

    // stall: late ack lands in skid, then HOLD
    step(1, 1, 0, 0, 1);
    chk("t2_hold_req", imem_req_o, 0);
    chk("t2_pc", pc_o, 32'h14);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("t2_hold_req2", imem_req_o, 0);
    step(1, 0, 0, 0, 1);
    chk("t2_pc_skid", pc_o, 32'h18);
    chk("t2_addr", imem_addr_o, 32'h1C);

    // branch while waiting for ack -> DROP
    step(1, 0, 1, 32'h200, 0);
    chk("t3_drop_req", imem_req_o, 1);
    chk("t3_flush", instr_valid_o, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("t3_addr", imem_addr_o, 32'h200);
    chk("t3_valid", instr_valid_o, 0);
    step(1, 0, 0, 0, 1);
    chk("t3_pc", pc_o, 32'h200);

    // branch on the ack edge, unaligned target
    step(1, 0, 1, 32'h103, 1);
    chk("t4_addr", imem_addr_o, 32'h100);
    chk("t4_valid", instr_valid_o, 0);

    // PC wraparound
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 0, 1);
    chk("t5_addr_wrap", imem_addr_o, 32'h0);
    chk("t5_pc", pc_o, 32'hFFFF_FFFC);

    // reset mid-FETCH, then in HOLD
    do_reset();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("t6_hold", imem_req_o, 0);
    do_reset();

    // start low mid-FETCH: ack captured, then idle
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t6_idle_req", imem_req_o, 0);
    chk("t6_idle_valid", instr_valid_o, 1);
    chk("t6_idle_pc", pc_o, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_idle_mstall", mem_stall_o, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0,
           $urandom(),
           $urandom_range(0, 9) < 6);
    end

    // drain
    n = 0;
    while ((q.size() != 0 || imem_req_o) && n < 40) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_req", imem_req_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
